// File: rtl/dac_spi_rx.sv
// SPI slave for the DAC link: oversamples the SPI pins, deframes 25-bit words
// and applies the decoded commands to a 16-entry input/DAC register model.
module dac_spi_rx #(
  parameter int FRAME_BITS = 25,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_data,
  input  logic                 spi_sclk,
  input  logic                 spi_sync,
  output logic                 frame_valid,
  output logic [3:0]           frame_comm,
  output logic [3:0]           frame_addr,
  output logic [15:0]          frame_data,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic                 dac_update,
  input  logic [3:0]           rd_addr,
  output logic [15:0]          rd_data,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2
  } state_e;

  localparam logic [5:0] FRAME_LEN = 6'(FRAME_BITS);

  logic [2:0]            data_sync_q, sclk_sync_q, sync_sync_q;
  logic                  data_s, sclk_rise, sync_s, sync_rise, sync_fall;
  state_e                state_q, state_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  eval, good, bad, upd_d;
  logic [1:0]            code_d;
  logic [3:0]            f_comm, f_addr;
  logic [15:0]           f_data;

  logic                  frame_valid_q, frame_err_q, dac_update_q;
  logic [3:0]            frame_comm_q, frame_addr_q;
  logic [15:0]           frame_data_q;
  logic [1:0]            err_code_q;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, err_cnt_q;
  logic [15:0]           input_reg_q [16];
  logic [15:0]           dac_reg_q   [16];

  // Data is taken from the older history stage: one extra cycle of setup
  // margin ahead of the synchronised sclk rise.
  assign data_s    = data_sync_q[2];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sync_s    = sync_sync_q[1];
  assign sync_rise = sync_sync_q[1] & ~sync_sync_q[2];
  assign sync_fall = ~sync_sync_q[1] & sync_sync_q[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_sync_q <= '0;
      sclk_sync_q <= '0;
      sync_sync_q <= '0;
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
    end else begin
      data_sync_q <= {data_sync_q[1:0], spi_data};
      sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
      sync_sync_q <= {sync_sync_q[1:0], spi_sync};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
    end
  end

  // A sync rise in RECV ends the frame; a coincident sclk rise is dropped.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    eval      = 1'b0;
    case (state_q)
      WAIT_IDLE: if (sync_s) state_d = IDLE;
      IDLE: begin
        if (sync_fall) begin
          bit_cnt_d = '0;
          shreg_d   = '0;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (sync_rise) begin
          eval    = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], data_s};
          if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    code_d = 2'b00;
    if (bit_cnt_q < FRAME_LEN)          code_d = 2'b01;
    else if (bit_cnt_q > FRAME_LEN)     code_d = 2'b10;
    else if (shreg_q[FRAME_BITS-1])     code_d = 2'b11;
    good   = eval && (code_d == 2'b00);
    bad    = eval && (code_d != 2'b00);
    f_comm = shreg_q[23:20];
    f_addr = shreg_q[19:16];
    f_data = shreg_q[15:0];
    upd_d  = good && (f_comm == 4'h2 || f_comm == 4'h3 || f_comm == 4'h8);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      dac_update_q  <= 1'b0;
      frame_comm_q  <= '0;
      frame_addr_q  <= '0;
      frame_data_q  <= '0;
      err_code_q    <= '0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        input_reg_q[i] <= '0;
        dac_reg_q[i]   <= '0;
      end
    end else begin
      frame_valid_q <= good;
      frame_err_q   <= bad;
      dac_update_q  <= upd_d;
      if (good) begin
        frame_comm_q <= f_comm;
        frame_addr_q <= f_addr;
        frame_data_q <= f_data;
        if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
        case (f_comm)
          4'h1: input_reg_q[f_addr] <= f_data;
          4'h2: dac_reg_q[f_addr] <= input_reg_q[f_addr];
          4'h3: begin
            input_reg_q[f_addr] <= f_data;
            dac_reg_q[f_addr]   <= f_data;
          end
          4'h8: begin
            for (int i = 0; i < 16; i++) begin
              input_reg_q[i] <= '0;
              dac_reg_q[i]   <= '0;
            end
          end
          default: ;
        endcase
      end
      if (bad) begin
        err_code_q <= code_d;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign dac_update  = dac_update_q;
  assign frame_comm  = frame_comm_q;
  assign frame_addr  = frame_addr_q;
  assign frame_data  = frame_data_q;
  assign err_code    = err_code_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign rd_data     = dac_reg_q[rd_addr];

endmodule

// File: tb/tb_dac_spi_rx.sv
// Bench for dac_spi_rx: drives SPI frames at several sclk rates and checks the
// decoder against a frame-level model of the register file and counters.
module tb_dac_spi_rx;

  logic        clk = 1'b0;
  logic        rst_n, spi_data, spi_sclk, spi_sync;
  logic [3:0]  rd_addr;
  logic        frame_valid, frame_err, dac_update;
  logic [3:0]  frame_comm, frame_addr;
  logic [15:0] frame_data, rd_data;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt, err_cnt;

  // Narrow-counter instance on the same pins, used to reach saturation quickly.
  logic        s_valid, s_err, s_upd;
  logic [3:0]  s_comm, s_addr;
  logic [15:0] s_data, s_rd_data;
  logic [1:0]  s_code;
  logic [2:0]  s_frame_cnt, s_err_cnt;

  dac_spi_rx dut (
    .clk(clk), .rst_n(rst_n), .spi_data(spi_data), .spi_sclk(spi_sclk),
    .spi_sync(spi_sync), .frame_valid(frame_valid), .frame_comm(frame_comm),
    .frame_addr(frame_addr), .frame_data(frame_data), .frame_err(frame_err),
    .err_code(err_code), .dac_update(dac_update), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  dac_spi_rx #(.FRAME_BITS(25), .CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .spi_data(spi_data), .spi_sclk(spi_sclk),
    .spi_sync(spi_sync), .frame_valid(s_valid), .frame_comm(s_comm),
    .frame_addr(s_addr), .frame_data(s_data), .frame_err(s_err),
    .err_code(s_code), .dac_update(s_upd), .rd_addr(rd_addr),
    .rd_data(s_rd_data), .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
  );

  // clock / reset
  always #10 clk = ~clk;

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];  // per frame: bit0 valid, bit1 err, bit2 dac_update

  logic [15:0] m_in  [16];
  logic [15:0] m_dac [16];
  logic [3:0]  m_comm, m_addr;
  logic [15:0] m_data;
  logic [1:0]  m_code;
  int          m_fcnt, m_ecnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int g, input int c, input int a, input int d);
    return 32'((g << 24) | (c << 20) | (a << 16) | (d & 32'hFFFF));
  endfunction

  function automatic int sat7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_in[i]  = '0;
      m_dac[i] = '0;
    end
    m_comm = '0; m_addr = '0; m_data = '0; m_code = '0;
    m_fcnt = 0;  m_ecnt = 0;
    exp_q.delete();
  endtask

  task automatic model_frame(input logic [31:0] word, input int counted);
    int c, a, d, code;
    bit upd;
    code = (counted < 25) ? 1 : (counted > 25) ? 2 : (((word >> 24) & 1) != 0) ? 3 : 0;
    upd  = 1'b0;
    if (code != 0) begin
      m_code = 2'(code);
      m_ecnt++;
      exp_q.push_back(32'd2);
    end else begin
      c = int'((word >> 20) & 15);
      a = int'((word >> 16) & 15);
      d = int'(word & 32'hFFFF);
      m_comm = 4'(c); m_addr = 4'(a); m_data = 16'(d);
      m_fcnt++;
      if (c == 1) m_in[a] = 16'(d);
      if (c == 2) begin m_dac[a] = m_in[a]; upd = 1'b1; end
      if (c == 3) begin m_in[a] = 16'(d); m_dac[a] = 16'(d); upd = 1'b1; end
      if (c == 8) begin
        for (int i = 0; i < 16; i++) begin m_in[i] = '0; m_dac[i] = '0; end
        upd = 1'b1;
      end
      exp_q.push_back(upd ? 32'd5 : 32'd1);
    end
  endtask

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    wait_clk(n);
    rst_n = 1'b1;
    model_reset();
    wait_clk(4);
  endtask

  task automatic check_outputs();
    check_eq("frame_comm", frame_comm, m_comm);
    check_eq("frame_addr", frame_addr, m_addr);
    check_eq("frame_data", frame_data, m_data);
    check_eq("err_code", err_code, m_code);
    check_eq("frame_cnt", frame_cnt, m_fcnt);
    check_eq("err_cnt", err_cnt, m_ecnt);
    check_eq("sat_frame_cnt", s_frame_cnt, sat7(m_fcnt));
    check_eq("sat_err_cnt", s_err_cnt, sat7(m_ecnt));
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      check_eq($sformatf("rd_data[%0d]", a), rd_data, m_dac[a]);
    end
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, input int half,
                            input int rst_at, input bit coincide);
    int v_idx, e_idx, u_idx, v_n, e_n, u_n;
    bit did_rst;
    logic [31:0] exp;
    v_idx = 0; e_idx = 0; u_idx = 0; v_n = 0; e_n = 0; u_n = 0;
    did_rst = 1'b0;
    wait_clk(1);
    spi_sync = 1'b0;
    spi_sclk = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_data = word[nbits-1-i];
      if (i == rst_at) begin
        do_reset(2);
        did_rst = 1'b1;
      end
      wait_clk(half);
      spi_sclk = 1'b1;
      if (coincide && i == nbits - 1) begin
        spi_sync = 1'b1;
      end else begin
        wait_clk(half);
        spi_sclk = 1'b0;
      end
    end
    if (!(coincide && nbits > 0)) begin
      wait_clk(half);
      spi_sync = 1'b1;
    end
    if (!did_rst) model_frame(word, coincide ? nbits - 1 : nbits);
    for (int k = 1; k <= 6; k++) begin
      wait_clk(1);
      if (frame_valid) begin v_n++; if (v_idx == 0) v_idx = k; end
      if (frame_err)   begin e_n++; if (e_idx == 0) e_idx = k; end
      if (dac_update)  begin u_n++; if (u_idx == 0) u_idx = k; end
    end
    spi_sclk = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd0;
    check_eq("valid_at", v_idx, exp[0] ? 3 : 0);
    check_eq("valid_len", v_n, {31'd0, exp[0]});
    check_eq("err_at", e_idx, exp[1] ? 3 : 0);
    check_eq("err_len", e_n, {31'd0, exp[1]});
    check_eq("upd_at", u_idx, exp[2] ? 3 : 0);
    check_eq("upd_len", u_n, {31'd0, exp[2]});
    check_outputs();
  endtask

  // stimulus
  initial begin
    logic [31:0] w;
    int nb, sel, cm, r;
    rst_n = 1'b0; spi_sync = 1'b1; spi_sclk = 1'b0; spi_data = 1'b0; rd_addr = '0;
    do_reset(3);
    check_eq("rst_valid", frame_valid, 0);
    check_eq("rst_err", frame_err, 0);
    check_eq("rst_upd", dac_update, 0);
    check_outputs();

    send_frame(mk(0, 3, 5, 16'hA5C3), 25, 16, -1, 1'b0);
    check_eq("tp1_data", frame_data, 16'hA5C3);
    rd_addr = 4'd5; #1;
    check_eq("tp1_rd5", rd_data, 16'hA5C3);

    send_frame(mk(0, 1, 2, 16'h1234), 25, 16, -1, 1'b0);
    send_frame(mk(0, 2, 2, 16'h0000), 25, 16, -1, 1'b0);
    rd_addr = 4'd2; #1;
    check_eq("tp2_rd2", rd_data, 16'h1234);

    send_frame(mk(0, 3, 7, 16'h00FF) >> 1, 24, 16, -1, 1'b0);
    send_frame(mk(0, 3, 7, 16'h00FF) | 32'h0200_0000, 26, 16, -1, 1'b0);
    send_frame(mk(1, 3, 7, 16'h00FF), 25, 16, -1, 1'b0);
    check_eq("tp3_errcnt", err_cnt, 3);

    send_frame(mk(0, 3, 9, 16'hBEEF), 25, 16, 10, 1'b0);
    send_frame(mk(0, 3, 9, 16'hCAFE), 25, 16, -1, 1'b0);

    send_frame(mk(0, 3, 15, 16'hFFFF), 25, 3, -1, 1'b0);
    send_frame(mk(0, 3, 4, 16'h5555), 25, 3, -1, 1'b1);
    check_eq("tp5_short", err_code, 2'b01);
    send_frame(32'd0, 0, 4, -1, 1'b0);

    for (int n = 0; n < 32; n++) begin
      sel = $urandom_range(0, 4);
      cm  = (sel == 0) ? 1 : (sel == 1) ? 2 : (sel == 2) ? 3 : (sel == 3) ? 8 : $urandom_range(0, 15);
      w   = mk(($urandom_range(0, 7) == 0) ? 1 : 0, cm,
               ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15),
               $urandom_range(0, 65535));
      r   = $urandom_range(0, 11);
      nb  = (r == 0) ? 24 : (r == 1) ? 26 : (r == 2) ? 0 : 25;
      if (nb == 24) w = w >> 1;
      if (nb == 26) w = w | (32'($urandom_range(0, 1)) << 25);
      send_frame(w, nb, $urandom_range(3, 6), -1, (nb == 25 && $urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
